// File: rtl/sw_reg_responder.sv
// Switch-side register endpoint for the address decoder.
// Executes one access per request and answers with a single-cycle ack.
module sw_reg_responder #(
  parameter int W_WIDTH    = 8,
  parameter int NUM_REGS   = 16,
  parameter int RESP_DELAY = 2,
  parameter int SW_ID      = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sel_en_in,
  input  logic               wr_rd_s_in,
  input  logic [W_WIDTH-1:0] addr_in,
  input  logic [W_WIDTH-1:0] wr_data_in,
  output logic [W_WIDTH-1:0] rd_data_out,
  output logic               ack_out,
  output logic               err_out,
  output logic               busy_out,
  output logic [7:0]         drop_cnt_out
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [W_WIDTH:0] NREGS = (W_WIDTH+1)'(NUM_REGS);
  localparam logic [W_WIDTH-1:0] ID_ADDR = '1;
  localparam logic [W_WIDTH-1:0] ID_VAL = W_WIDTH'(SW_ID);
  localparam logic [3:0] CNT_INIT =
    (RESP_DELAY > 0) ? 4'(RESP_DELAY - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  state_t state, state_d;
  logic [3:0] cnt, cnt_d;
  logic cap;

  logic               wr_q, id_q, ok_q;
  logic [IDX_W-1:0]   idx_q;
  logic [W_WIDTH-1:0] data_q;
  logic [W_WIDTH-1:0] regs [NUM_REGS];

  logic               in_rng, is_id, ok_in;
  logic               e_wr, e_id, e_ok;
  logic [IDX_W-1:0]   e_idx;
  logic [W_WIDTH-1:0] e_data, rd_d;

  // Decode the incoming request; writes never target the ID register.
  always_comb begin
    in_rng = {1'b0, addr_in} < NREGS;
    is_id  = (addr_in == ID_ADDR);
    ok_in  = wr_rd_s_in ? (in_rng && !is_id) : (in_rng || is_id);
  end

  // With zero delay the ack edge is the capture edge, so bypass the latch.
  always_comb begin
    e_wr   = cap ? wr_rd_s_in : wr_q;
    e_id   = cap ? is_id : id_q;
    e_ok   = cap ? ok_in : ok_q;
    e_idx  = cap ? addr_in[IDX_W-1:0] : idx_q;
    e_data = cap ? wr_data_in : data_q;
    rd_d   = '1;
    if (e_ok) begin
      if (e_wr)      rd_d = e_data;
      else if (e_id) rd_d = ID_VAL;
      else           rd_d = regs[e_idx];
    end
  end

  // Next-state logic: capture in IDLE, count down in WAIT, one ACK cycle.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    cap     = 1'b0;
    unique case (state)
      IDLE: begin
        if (sel_en_in) begin
          cap = 1'b1;
          if (RESP_DELAY == 0) begin
            state_d = ACK;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_d = ACK;
        else             cnt_d = cnt - 4'd1;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Latch the request attributes on capture.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_q   <= 1'b0;
      id_q   <= 1'b0;
      ok_q   <= 1'b0;
      idx_q  <= '0;
      data_q <= '0;
    end else if (cap) begin
      wr_q   <= wr_rd_s_in;
      id_q   <= is_id;
      ok_q   <= ok_in;
      idx_q  <= addr_in[IDX_W-1:0];
      data_q <= wr_data_in;
    end
  end

  // Register bank; the write lands at the end of the ACK cycle.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (state == ACK && wr_q && ok_q) begin
      regs[idx_q] <= data_q;
    end
  end

  // Registered response outputs; rd_data holds between acks.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      ack_out     <= 1'b0;
      err_out     <= 1'b0;
      busy_out    <= 1'b0;
      rd_data_out <= '0;
    end else begin
      ack_out  <= (state_d == ACK);
      busy_out <= (state_d != IDLE);
      if (state_d == ACK) begin
        rd_data_out <= rd_d;
        err_out     <= !e_ok;
      end else begin
        err_out <= 1'b0;
      end
    end
  end

  // Saturating count of strobes that arrive while busy.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      drop_cnt_out <= 8'd0;
    end else if (sel_en_in && state != IDLE && drop_cnt_out != 8'hFF) begin
      drop_cnt_out <= drop_cnt_out + 8'd1;
    end
  end

endmodule

// File: tb/tb_sw_reg_responder.sv
// Directed bench for sw_reg_responder.
// Main instance: delay 2, id 3; second instance: delay 0.
module tb_sw_reg_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       sel0 = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] wdat = 8'h00;

  logic [7:0] rd, rd0, drop, drop0;
  logic       ack, err, busy, ack0, err0, busy0;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sw_reg_responder #(
    .W_WIDTH(8), .NUM_REGS(16), .RESP_DELAY(2), .SW_ID(3)
  ) u_dut (
    .clk(clk), .rst_n(rst), .sel_en_in(sel), .wr_rd_s_in(wr),
    .addr_in(addr), .wr_data_in(wdat), .rd_data_out(rd),
    .ack_out(ack), .err_out(err), .busy_out(busy),
    .drop_cnt_out(drop)
  );

  sw_reg_responder #(
    .W_WIDTH(8), .NUM_REGS(16), .RESP_DELAY(0), .SW_ID(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst), .sel_en_in(sel0), .wr_rd_s_in(wr),
    .addr_in(addr), .wr_data_in(wdat), .rd_data_out(rd0),
    .ack_out(ack0), .err_out(err0), .busy_out(busy0),
    .drop_cnt_out(drop0)
  );

  // Issue one pulse at a negedge; return ack latency and ack-cycle values.
  task automatic req(input logic w, input logic [7:0] a,
                     input logic [7:0] d, output int lat,
                     output logic [7:0] r, output logic e,
                     output logic bz);
    sel = 1'b1; wr = w; addr = a; wdat = d;
    @(negedge clk);
    sel = 1'b0;
    lat = 1;
    bz = 1'b1;
    while (ack !== 1'b1 && lat < 20) begin
      bz = bz & busy;
      @(negedge clk);
      lat++;
    end
    if (ack !== 1'b1) lat = -1;
    bz = bz & busy;
    r = rd;
    e = err;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({ack, err, busy, rd, drop} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outs got=%h want=0", {ack, err, busy, rd, drop});
    end
    n_cmp++;
    if ({ack0, err0, busy0, rd0, drop0} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outs0 got=%h want=0",
               {ack0, err0, busy0, rd0, drop0});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    int l; logic [7:0] r; logic e, b;
    req(1'b1, 8'h03, 8'hA5, l, r, e, b);
    n_cmp++;
    if (l !== 3 || r !== 8'hA5 || e !== 1'b0 || b !== 1'b1) begin
      n_fail++;
      $display("FAIL wr03 lat=%0d rd=%h err=%b busy=%b want 3 a5 0 1",
               l, r, e, b);
    end
    @(negedge clk);
    n_cmp++;
    if (ack !== 1'b0 || busy !== 1'b0 || rd !== 8'hA5) begin
      n_fail++;
      $display("FAIL post_ack ack=%b busy=%b rd=%h want 0 0 a5",
               ack, busy, rd);
    end
    req(1'b0, 8'h03, 8'h00, l, r, e, b);
    n_cmp++;
    if (l !== 3 || r !== 8'hA5 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_rd03 lat=%0d rd=%h err=%b want 3 a5 0", l, r, e);
    end
    @(negedge clk);
    req(1'b0, 8'h04, 8'h00, l, r, e, b);
    n_cmp++;
    if (l !== 3 || r !== 8'h00 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL rd04 lat=%0d rd=%h err=%b want 3 00 0", l, r, e);
    end
    @(negedge clk);
  endtask

  task automatic test_range;
    int l; logic [7:0] r; logic e, b;
    req(1'b1, 8'h20, 8'h11, l, r, e, b);
    n_cmp++;
    if (l !== 3 || r !== 8'hFF || e !== 1'b1) begin
      n_fail++;
      $display("FAIL wr20 lat=%0d rd=%h err=%b want 3 ff 1", l, r, e);
    end
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b0 || rd !== 8'hFF) begin
      n_fail++;
      $display("FAIL err_clear err=%b rd=%h want 0 ff", err, rd);
    end
    req(1'b0, 8'h00, 8'h00, l, r, e, b);
    n_cmp++;
    if (l !== 3 || r !== 8'h00 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL rd00 lat=%0d rd=%h err=%b want 3 00 0", l, r, e);
    end
    @(negedge clk);
    req(1'b0, 8'hFF, 8'h00, l, r, e, b);
    n_cmp++;
    if (l !== 3 || r !== 8'h03 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_id lat=%0d rd=%h err=%b want 3 03 0", l, r, e);
    end
    @(negedge clk);
    req(1'b1, 8'hFF, 8'h55, l, r, e, b);
    n_cmp++;
    if (l !== 3 || r !== 8'hFF || e !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_id lat=%0d rd=%h err=%b want 3 ff 1", l, r, e);
    end
    @(negedge clk);
    req(1'b0, 8'h0F, 8'h00, l, r, e, b);
    n_cmp++;
    if (r !== 8'h00 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL rd0f rd=%h err=%b want 00 0", r, e);
    end
    @(negedge clk);
  endtask

  task automatic test_drops;
    int acks;
    acks = 0;
    sel = 1'b1; wr = 1'b0; addr = 8'h03;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 3) sel = 1'b0;
      if (ack === 1'b1) acks++;
      if (i == 3) begin
        n_cmp++;
        if (ack !== 1'b1 || rd !== 8'hA5) begin
          n_fail++;
          $display("FAIL drop_ack ack=%b rd=%h want 1 a5", ack, rd);
        end
      end
    end
    n_cmp++;
    if (acks !== 1 || drop !== 8'd2) begin
      n_fail++;
      $display("FAIL drop2 acks=%0d drop=%0d want 1 2", acks, drop);
    end
    sel = 1'b1;
    repeat (400) @(negedge clk);
    sel = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (drop !== 8'hFF || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_sat drop=%h busy=%b want ff 0", drop, busy);
    end
  endtask

  task automatic test_reset_inflight;
    int l, acks; logic [7:0] r; logic e, b;
    acks = 0;
    sel = 1'b1; wr = 1'b1; addr = 8'h05; wdat = 8'h77;
    @(negedge clk);
    sel = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({ack, err, busy, rd, drop} !== 19'd0) begin
      n_fail++;
      $display("FAIL mid_reset got=%h want=0", {ack, err, busy, rd, drop});
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ack === 1'b1) acks++;
    end
    n_cmp++;
    if (acks !== 0) begin
      n_fail++;
      $display("FAIL no_ack acks=%0d want 0", acks);
    end
    req(1'b0, 8'h05, 8'h00, l, r, e, b);
    n_cmp++;
    if (l !== 3 || r !== 8'h00) begin
      n_fail++;
      $display("FAIL rd05 lat=%0d rd=%h want 3 00", l, r);
    end
    @(negedge clk);
    req(1'b0, 8'h03, 8'h00, l, r, e, b);
    n_cmp++;
    if (r !== 8'h00) begin
      n_fail++;
      $display("FAIL rd03_cleared rd=%h want 00", r);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_delay;
    sel0 = 1'b1; wr = 1'b1; addr = 8'h07; wdat = 8'h3C;
    @(negedge clk);
    sel0 = 1'b0;
    n_cmp++;
    if (ack0 !== 1'b1 || busy0 !== 1'b1 || rd0 !== 8'h3C ||
        err0 !== 1'b0) begin
      n_fail++;
      $display("FAIL d0_wr ack=%b busy=%b rd=%h err=%b want 1 1 3c 0",
               ack0, busy0, rd0, err0);
    end
    sel0 = 1'b1; wr = 1'b0; addr = 8'h07;
    @(negedge clk);
    sel0 = 1'b0;
    n_cmp++;
    if (ack0 !== 1'b0 || busy0 !== 1'b0 || drop0 !== 8'd1) begin
      n_fail++;
      $display("FAIL d0_drop ack=%b busy=%b drop=%0d want 0 0 1",
               ack0, busy0, drop0);
    end
    sel0 = 1'b1;
    @(negedge clk);
    sel0 = 1'b0;
    n_cmp++;
    if (ack0 !== 1'b1 || rd0 !== 8'h3C) begin
      n_fail++;
      $display("FAIL d0_rd ack=%b rd=%h want 1 3c", ack0, rd0);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_range;
    test_drops;
    test_reset_inflight;
    test_zero_delay;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_reg_responder.md
Name: sw_reg_responder

Overview:
Switch-side endpoint of the address-decoder-to-switch interface. It consumes one sel_en bit, wr_rd_s, addr and wr_data from the decoder's TX scheduler, and executes the access against a local register bank. It then returns rd_data with a single-cycle ack, which the decoder's RX side uses to release the switch's busy state. One instance sits behind each sel_en bit; the decoder ORs or muxes the instances' rd_data/ack onto its NUM_SW_INST-wide inputs.

Parameters:
W_WIDTH, 8, data and address width; matches decoder W_WIDTH.
NUM_REGS, 16, register bank depth; power of 2, 2..256.
RESP_DELAY, 2, wait cycles between request capture and ack; 0..15.
SW_ID, 0, instance index; read-only, returned at address 8'hFF.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset; synchronous and active-high (rst_n=1 resets), despite the name.
sel_en_in  in  1  request strobe; this switch's bit of decoder sel_en.
wr_rd_s_in  in  1  1 = write, 0 = read; sampled with sel_en_in.
addr_in  in  W_WIDTH  register address; sampled with sel_en_in.
wr_data_in  in  W_WIDTH  write data; sampled with sel_en_in.
rd_data_out  out  W_WIDTH  response data; valid while ack_out=1, held afterwards.
ack_out  out  1  one-cycle completion pulse.
err_out  out  1  asserted with ack_out when the access was out of range.
busy_out  out  1  1 while a request is in flight (state != IDLE).
drop_cnt_out  out  8  saturating count of requests dropped while busy.

Behaviour:
- Reset (rst_n=1 at a clk edge):
  - state=IDLE; all registers = 0.
  - rd_data_out=0, ack_out=0, err_out=0, busy_out=0, drop_cnt_out=0.
  - Reset has priority over everything, including mid-WAIT or ACK. An in-flight request is discarded with no ack, and its write is not performed.
- Request capture:
  - In IDLE, sel_en_in=1 latches wr_rd_s_in, addr_in and wr_data_in.
  - Range check: in_range = (addr_in < NUM_REGS). Register index = addr_in[log2(NUM_REGS)-1:0].
  - addr 8'hFF is a special read-only ID register: read returns SW_ID, and it is always in range for reads.
- FSM (states IDLE, WAIT, ACK):
  - IDLE -> WAIT with cnt=RESP_DELAY-1 on capture when RESP_DELAY>0. IDLE -> ACK when RESP_DELAY=0.
  - WAIT: cnt decrements each cycle; at cnt=0 go to ACK.
  - ACK: lasts exactly one cycle, then IDLE.
- Latency: with sel_en_in high at edge T, ack_out is high in cycle T+RESP_DELAY+1. busy_out is high from T+1 through the ACK cycle inclusive.
- ACK cycle outputs:
  - ack_out=1.
  - Read in range: rd_data_out = reg[idx] (or SW_ID for 8'hFF).
  - Write in range: reg[idx] <= captured data at the end of the ACK cycle; rd_data_out = captured write data (echo).
  - Out of range (write to any addr >= NUM_REGS including 8'hFF, or read of addr >= NUM_REGS other than 8'hFF): err_out=1, no register change, rd_data_out = {W_WIDTH{1'b1}}.
- After ACK: rd_data_out holds its last value. err_out and ack_out return to 0.
- Back-to-back requests: sel_en_in=1 in the cycle immediately after ACK (state IDLE) is accepted. A read following a write to the same address returns the new value.
- Drops: sel_en_in=1 while in WAIT or ACK is ignored and drop_cnt_out increments by 1, saturating at 8'hFF. No state or register effect.
- sel_en_in held high across several cycles counts as one request plus one drop per extra busy cycle. The decoder contract is single-cycle pulses.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
1. Reset, then write addr=8'h03 data=8'hA5 (RESP_DELAY=2): sel at T -> ack_out=1 at T+3, rd_data_out=8'hA5, err_out=0; busy_out=1 for T+1..T+3.
2. Read addr=8'h03 issued the cycle after scenario 1's ack -> ack 3 cycles later with rd_data_out=8'hA5; a read of addr=8'h04 returns 8'h00.
3. Write addr=8'h20 (NUM_REGS=16) data=8'h11 -> ack with err_out=1, rd_data_out=8'hFF; a subsequent read of 8'h00 still returns 8'h00.
4. Read addr=8'hFF with SW_ID=3 -> rd_data_out=8'h03, err_out=0; a write to 8'hFF -> err_out=1.
5. Pulse sel_en_in at T and at T+1 and T+2 (busy) -> a single ack at T+3, drop_cnt_out=2. Repeating the drop 300 times -> drop_cnt_out saturates at 8'hFF.
6. Start a write at T, assert rst_n=1 at T+1 -> no ack, all outputs 0, register unchanged (read returns 8'h00). Also run with RESP_DELAY=0 -> ack at T+1.
